dm_store_sequencer: RTL and testbench
=====================================

# dm_store_sequencer

Schedules all writes to the data-memory write port. Arbitrates between single scalar stores from the RV32IMC core and strided multi-element vector stores from the vector coprocessor. Each winning store is formatted into a word-aligned address, a lane-shifted write word and a 4-bit byte-enable, then registered onto the port. Sits between the core's MEM stage / coprocessor store unit and the data memory.

## Interface
Parameters:
- `MAX_ELEMS`, default 16: maximum vector element count; sets the width of `vs_count`, which is `$clog2(MAX_ELEMS)+1`.

Ports:
- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `sc_valid`  in  1  scalar store request.
- `sc_ready`  out  1  scalar request accepted this cycle.
- `sc_addr`  in  32  scalar byte address.
- `sc_data`  in  32  scalar store operand.
- `sc_sel`  in  2  store width: 0 = byte, 1 = half, 2 = word.
- `vs_valid`  in  1  vector store command request.
- `vs_ready`  out  1  vector command accepted this cycle.
- `vs_base`  in  32  address of element 0.
- `vs_stride`  in  32  byte stride between elements (two's complement).
- `vs_count`  in  `$clog2(MAX_ELEMS)+1`  element count, 0..`MAX_ELEMS`.
- `vs_sew`  in  2  element width, same encoding as `sc_sel`.
- `vs_elem_data`  in  32  current element operand.
- `vs_elem_ack`  out  1  current element was issued this cycle; present the next element by the next edge.
- `vs_done`  out  1  one-cycle pulse when a vector command completes.
- `dm_addr`  out  32  word address: the store's byte address with bits [1:0] forced to 0.
- `dm_wdata`  out  32  store data shifted into its byte lanes.
- `dm_write`  out  4  byte write enables.
- `st_misalign`  out  1  one-cycle pulse: the issued store was misaligned and was suppressed.

## Operation
- Lane formatting (combinational), given byte offset `o` = addr[1:0]:
  - Data is zero-extended to the store width, then shifted left by 8*`o`.
  - Byte enables:
    - byte: `o`=0 → 1000, 1 → 0100, 2 → 0010, 3 → 0001.
    - half: `o`=0 → 1100, 2 → 0011.
    - word: `o`=0 → 1111.
  - Any other width/offset combination is misaligned. `dm_write` = 0000 and `st_misalign` pulses. A `sel`/`sew` value of 3 is also treated as misaligned.
- FSM states: IDLE, VEC.
- IDLE:
  - `vs_ready` = `vs_valid` & ~`sc_valid`.
  - On accept, latch base, stride, count and sew. Clear element index k and set running address A = base.
  - If count = 0, go straight to a `vs_done` pulse and stay in IDLE; no writes occur.
  - Otherwise, go to VEC.
- VEC:
  - Each cycle with `sc_valid` = 0, issue element k at address A and pulse `vs_elem_ack`. Then A ← A + stride (wraps modulo 2^32) and k ← k+1.
  - When element count−1 is issued, return to IDLE and pulse `vs_done` on the next cycle.
  - `vs_ready` = 0 throughout.
  - A misaligned element is still acked and counted.
- Scalar priority: `sc_ready` = ~`rst`. A scalar store is accepted in any state and in any cycle it is valid, and it preempts that cycle's vector element, which then waits.
- Only one store reaches the port per cycle.

## Timing
- Reset values:
  - `dm_addr`, `dm_wdata`, `dm_write`, `st_misalign`, `vs_done` = 0.
  - State = IDLE, k = 0.
  - `sc_ready`, `vs_ready` and `vs_elem_ack` are 0 while `rst` is high.
- Latency: a store accepted in cycle N appears on `dm_*` in cycle N+1. `dm_write` returns to 0000 in any cycle with no store issued.
- `vs_elem_ack` is combinational in the issue cycle. `vs_elem_data` is sampled in that same cycle.
- `vs_done` is asserted in the cycle after the last element issue, together with that element's `dm_*` output.
- Back-to-back vector commands: a new command may be accepted in the cycle `vs_done` is high.
- Reset mid-VEC: the command is abandoned, with no `vs_done` and no further writes.
- Simultaneous `sc_valid` & `vs_valid` in IDLE: the scalar store issues and the vector command waits.

## Structure
- Shared package `dm_pkg` holds:
  - store-width constants SB = 0, SH = 1, SW = 2;
  - FSM state enum;
  - `MAX_ELEMS` default.
- Sub-module `dm_lane_format` is purely combinational and is instantiated once on the arbitrated address/data/sel:
  - inputs: addr[1:0], data, sel;
  - outputs: wdata, be, misalign.

## Test plan
- Scalar sb: addr 0x1003, data 0xAB → next cycle `dm_addr` 0x1000, `dm_wdata` 0xAB000000, `dm_write` 0001.
- Scalar sh: addr 0x2001 → `dm_write` 0000, `st_misalign` pulses once, no write.
- Vector: base 0x100, stride 4, count 3, sew word, elements 0x11/0x22/0x33 → writes to 0x100, 0x104, 0x108 with `dm_write` 1111 on three consecutive cycles; `vs_done` coincides with the third write.
- Vector: base 0x200, stride −2, count 2, sew half → `dm_addr` 0x200 with `dm_write` 1100, then `dm_addr` 0x1FC with `dm_write` 0011.
- Contention: `sc_valid` held during vector element 1 of 3 for 2 cycles → both scalar stores issue first, element 1 issues in the third cycle, and the total is 5 writes.
- Count 0 → no `dm_write`, `vs_done` one cycle after accept. Separately, `rst` asserted mid-VEC → all outputs 0 next cycle and `vs_done` never pulses.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store sequencer: store widths,
// sequencer states and the default vector length limit.
package dm_pkg;

    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;

    localparam int MAX_ELEMS_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_lane_format.sv
// Places a store operand into its byte lanes and derives the byte enables
// from the width and the byte offset within the word.
module dm_lane_format
    import dm_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [1:0]  sel,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign
);

    logic [4:0] shamt;

    always_comb begin
        shamt    = {addr, 3'b000};
        wdata    = '0;
        be       = 4'b0000;
        misalign = 1'b0;
        case (sel)
            SB: begin
                wdata = {24'b0, data[7:0]} << shamt;
                be    = 4'b1000 >> addr;
            end
            SH: begin
                wdata = {16'b0, data[15:0]} << shamt;
                if (addr == 2'd0)      be = 4'b1100;
                else if (addr == 2'd2) be = 4'b0011;
                else                   misalign = 1'b1;
            end
            SW: begin
                wdata = data;
                if (addr == 2'd0) be = 4'b1111;
                else              misalign = 1'b1;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_store_sequencer.sv
// Arbitrates scalar stores and strided vector stores onto the single
// data-memory write port; scalar stores always win the cycle.
//
// state | meaning
// IDLE  | no vector command active; may accept a new one
// VEC   | issuing elements of the latched vector command
module dm_store_sequencer
    import dm_pkg::*;
#(
    parameter int MAX_ELEMS = MAX_ELEMS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sc_valid,
    output logic                        sc_ready,
    input  logic [31:0]                 sc_addr,
    input  logic [31:0]                 sc_data,
    input  logic [1:0]                  sc_sel,
    input  logic                        vs_valid,
    output logic                        vs_ready,
    input  logic [31:0]                 vs_base,
    input  logic [31:0]                 vs_stride,
    input  logic [$clog2(MAX_ELEMS):0]  vs_count,
    input  logic [1:0]                  vs_sew,
    input  logic [31:0]                 vs_elem_data,
    output logic                        vs_elem_ack,
    output logic                        vs_done,
    output logic [31:0]                 dm_addr,
    output logic [31:0]                 dm_wdata,
    output logic [3:0]                  dm_write,
    output logic                        st_misalign
);

    localparam int CW = $clog2(MAX_ELEMS) + 1;

    dm_state_e     state;
    logic [CW-1:0] k;
    logic [CW-1:0] count_q;
    logic [31:0]   run_addr;
    logic [31:0]   stride_q;
    logic [1:0]    sew_q;

    logic          issue;
    logic [31:0]   arb_addr;
    logic [31:0]   arb_data;
    logic [1:0]    arb_sel;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;
    logic          fmt_misalign;

    // A valid scalar store steals the cycle from any pending vector element.
    always_comb begin
        sc_ready    = ~rst;
        vs_ready    = ~rst & (state == IDLE) & vs_valid & ~sc_valid;
        vs_elem_ack = ~rst & (state == VEC) & ~sc_valid;
        issue       = (~rst & sc_valid) | vs_elem_ack;
        arb_addr    = sc_valid ? sc_addr : run_addr;
        arb_data    = sc_valid ? sc_data : vs_elem_data;
        arb_sel     = sc_valid ? sc_sel  : sew_q;
    end

    dm_lane_format u_lane_format (
        .addr     (arb_addr[1:0]),
        .data     (arb_data),
        .sel      (arb_sel),
        .wdata    (fmt_wdata),
        .be       (fmt_be),
        .misalign (fmt_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            count_q     <= '0;
            run_addr    <= '0;
            stride_q    <= '0;
            sew_q       <= SB;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            dm_write    <= 4'b0000;
            st_misalign <= 1'b0;
            vs_done     <= 1'b0;
        end else begin
            dm_write    <= 4'b0000;
            st_misalign <= 1'b0;
            vs_done     <= 1'b0;
            if (issue) begin
                dm_addr     <= {arb_addr[31:2], 2'b00};
                dm_wdata    <= fmt_wdata;
                dm_write    <= fmt_be;
                st_misalign <= fmt_misalign;
            end
            case (state)
                IDLE: begin
                    if (vs_ready) begin
                        count_q  <= vs_count;
                        stride_q <= vs_stride;
                        sew_q    <= vs_sew;
                        run_addr <= vs_base;
                        k        <= '0;
                        if (vs_count == '0) vs_done <= 1'b1;
                        else                state   <= VEC;
                    end
                end
                VEC: begin
                    if (vs_elem_ack) begin
                        run_addr <= run_addr + stride_q;
                        k        <= k + CW'(1);
                        if (k == count_q - CW'(1)) begin
                            state   <= IDLE;
                            vs_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_sequencer.sv
// Directed bench for the store sequencer: scalar formatting, vector strides,
// scalar preemption, empty and back-to-back commands, and mid-command reset.
module tb_dm_store_sequencer;

    logic        clk;
    logic        rst;
    logic        sc_valid;
    logic        sc_ready;
    logic [31:0] sc_addr;
    logic [31:0] sc_data;
    logic [1:0]  sc_sel;
    logic        vs_valid;
    logic        vs_ready;
    logic [31:0] vs_base;
    logic [31:0] vs_stride;
    logic [4:0]  vs_count;
    logic [1:0]  vs_sew;
    logic [31:0] vs_elem_data;
    logic        vs_elem_ack;
    logic        vs_done;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_write;
    logic        st_misalign;

    int total = 0;
    int bad   = 0;

    dm_store_sequencer #(.MAX_ELEMS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sc_valid     (sc_valid),
        .sc_ready     (sc_ready),
        .sc_addr      (sc_addr),
        .sc_data      (sc_data),
        .sc_sel       (sc_sel),
        .vs_valid     (vs_valid),
        .vs_ready     (vs_ready),
        .vs_base      (vs_base),
        .vs_stride    (vs_stride),
        .vs_count     (vs_count),
        .vs_sew       (vs_sew),
        .vs_elem_data (vs_elem_data),
        .vs_elem_ack  (vs_elem_ack),
        .vs_done      (vs_done),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_write     (dm_write),
        .st_misalign  (st_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input logic [31:0] base, input logic [31:0] stride,
                             input logic [4:0] count, input logic [1:0] sew);
        vs_valid  = 1'b1;
        vs_base   = base;
        vs_stride = stride;
        vs_count  = count;
        vs_sew    = sew;
    endtask

    task automatic test_reset;
        rst = 1'b1; sc_valid = 1'b1; vs_valid = 1'b1;
        sc_addr = 32'h10; sc_data = 32'h1; sc_sel = 2'd2;
        vs_base = 0; vs_stride = 0; vs_count = 0; vs_sew = 0; vs_elem_data = 0;
        tick();
        tick();
        total++; if (sc_ready !== 1'b0) begin bad++; $display("FAIL reset_sc_ready got %b want 0", sc_ready); end
        total++; if (vs_ready !== 1'b0) begin bad++; $display("FAIL reset_vs_ready got %b want 0", vs_ready); end
        total++; if (vs_elem_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", vs_elem_ack); end
        total++; if ({dm_addr, dm_wdata, dm_write, st_misalign, vs_done} !== 70'd0) begin
            bad++; $display("FAIL reset_outputs got addr=%h wdata=%h we=%b mis=%b done=%b want all zero",
                            dm_addr, dm_wdata, dm_write, st_misalign, vs_done);
        end
        sc_valid = 1'b0; vs_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scalar;
        logic [31:0] a_tab [4] = '{32'h1003, 32'h2002, 32'h3000, 32'h2001};
        logic [31:0] d_tab [4] = '{32'h000000AB, 32'h1234BEEF, 32'hCAFEF00D, 32'h00001234};
        logic [1:0]  s_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
        logic [31:0] ea_tab[4] = '{32'h1000, 32'h2000, 32'h3000, 32'h2000};
        logic [31:0] ew_tab[4] = '{32'hAB000000, 32'hBEEF0000, 32'hCAFEF00D, 32'h0};
        logic [3:0]  eb_tab[4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};
        logic        em_tab[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            sc_valid = 1'b1; sc_addr = a_tab[i]; sc_data = d_tab[i]; sc_sel = s_tab[i];
            #1;
            total++; if (sc_ready !== 1'b1) begin bad++; $display("FAIL scalar%0d_ready got %b want 1", i, sc_ready); end
            tick();
            sc_valid = 1'b0;
            total++; if (dm_addr !== ea_tab[i]) begin bad++; $display("FAIL scalar%0d_addr got %h want %h", i, dm_addr, ea_tab[i]); end
            total++; if (dm_write !== eb_tab[i]) begin bad++; $display("FAIL scalar%0d_we got %b want %b", i, dm_write, eb_tab[i]); end
            total++; if (st_misalign !== em_tab[i]) begin bad++; $display("FAIL scalar%0d_mis got %b want %b", i, st_misalign, em_tab[i]); end
            if (!em_tab[i]) begin
                total++; if (dm_wdata !== ew_tab[i]) begin bad++; $display("FAIL scalar%0d_wdata got %h want %h", i, dm_wdata, ew_tab[i]); end
            end
            tick();
            total++; if (dm_write !== 4'b0000 || st_misalign !== 1'b0) begin
                bad++; $display("FAIL scalar%0d_idle got we=%b mis=%b want 0000/0", i, dm_write, st_misalign);
            end
        end
    endtask

    task automatic test_vector;
        // two commands: word stride +4 x3, half stride -2 x2
        logic [31:0] d_tab [5] = '{32'h11, 32'h22, 32'h33, 32'hAAAA, 32'hBBBB};
        logic [31:0] ea_tab[5] = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h1FC};
        logic [31:0] ew_tab[5] = '{32'h11, 32'h22, 32'h33, 32'h0000AAAA, 32'hBBBB0000};
        logic [3:0]  eb_tab[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b0011};
        logic        ed_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 2; c++) begin
            if (c == 0) start_vec(32'h100, 32'd4, 5'd3, 2'd2);
            else        start_vec(32'h200, 32'hFFFF_FFFE, 5'd2, 2'd1);
            #1;
            total++; if (vs_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_ready got %b want 1", c, vs_ready); end
            tick();
            vs_valid = 1'b0;
            for (int e = (c == 0 ? 0 : 3); e < (c == 0 ? 3 : 5); e++) begin
                vs_elem_data = d_tab[e];
                #1;
                total++; if (vs_elem_ack !== 1'b1) begin bad++; $display("FAIL vec_e%0d_ack got %b want 1", e, vs_elem_ack); end
                total++; if (vs_ready !== 1'b0) begin bad++; $display("FAIL vec_e%0d_busy got %b want 0", e, vs_ready); end
                tick();
                total++; if (dm_addr !== ea_tab[e] || dm_wdata !== ew_tab[e] || dm_write !== eb_tab[e]) begin
                    bad++; $display("FAIL vec_e%0d_port got %h/%h/%b want %h/%h/%b", e,
                                    dm_addr, dm_wdata, dm_write, ea_tab[e], ew_tab[e], eb_tab[e]);
                end
                total++; if (vs_done !== ed_tab[e]) begin bad++; $display("FAIL vec_e%0d_done got %b want %b", e, vs_done, ed_tab[e]); end
            end
            #1;
            total++; if (vs_elem_ack !== 1'b0) begin bad++; $display("FAIL vec%0d_ack_after got %b want 0", c, vs_elem_ack); end
            tick();
            total++; if (vs_done !== 1'b0 || dm_write !== 4'b0000) begin
                bad++; $display("FAIL vec%0d_tail got done=%b we=%b want 0/0000", c, vs_done, dm_write);
            end
        end
    endtask

    task automatic test_contention;
        // per cycle: scalar valid, scalar addr, expected ack, expected port addr/data, done
        logic        sv_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] sa_tab [5] = '{32'h0, 32'h500, 32'h504, 32'h0, 32'h0};
        logic        ack_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ea_tab [5] = '{32'h400, 32'h500, 32'h504, 32'h404, 32'h408};
        logic [31:0] ew_tab [5] = '{32'hE0, 32'h55, 32'h55, 32'hE1, 32'hE2};
        logic        ed_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int writes = 0;
        int elem = 0;
        start_vec(32'h400, 32'd4, 5'd3, 2'd2);
        tick();
        vs_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sc_valid = sv_tab[c]; sc_addr = sa_tab[c]; sc_data = 32'h55; sc_sel = 2'd2;
            vs_elem_data = 32'hE0 + elem;
            #1;
            total++; if (vs_elem_ack !== ack_tab[c]) begin bad++; $display("FAIL cont_c%0d_ack got %b want %b", c, vs_elem_ack, ack_tab[c]); end
            if (ack_tab[c]) elem++;
            tick();
            if (dm_write !== 4'b0000) writes++;
            total++; if (dm_addr !== ea_tab[c] || dm_wdata !== ew_tab[c] || dm_write !== 4'b1111) begin
                bad++; $display("FAIL cont_c%0d_port got %h/%h/%b want %h/%h/1111", c,
                                dm_addr, dm_wdata, dm_write, ea_tab[c], ew_tab[c]);
            end
            total++; if (vs_done !== ed_tab[c]) begin bad++; $display("FAIL cont_c%0d_done got %b want %b", c, vs_done, ed_tab[c]); end
        end
        sc_valid = 1'b0;
        tick();
        if (dm_write !== 4'b0000) writes++;
        total++; if (writes !== 5) begin bad++; $display("FAIL cont_writes got %0d want 5", writes); end
    endtask

    task automatic test_count_zero;
        start_vec(32'h900, 32'd4, 5'd0, 2'd2);
        #1;
        total++; if (vs_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got %b want 1", vs_ready); end
        tick();
        vs_valid = 1'b0;
        #1;
        total++; if (vs_done !== 1'b1 || dm_write !== 4'b0000) begin
            bad++; $display("FAIL zero_done got done=%b we=%b want 1/0000", vs_done, dm_write);
        end
        total++; if (vs_elem_ack !== 1'b0) begin bad++; $display("FAIL zero_ack got %b want 0", vs_elem_ack); end
        tick();
        total++; if (vs_done !== 1'b0 || dm_write !== 4'b0000) begin
            bad++; $display("FAIL zero_tail got done=%b we=%b want 0/0000", vs_done, dm_write);
        end
    endtask

    task automatic test_back_to_back;
        start_vec(32'h600, 32'd4, 5'd1, 2'd2);
        tick();
        vs_valid = 1'b0; vs_elem_data = 32'h66;
        tick();
        total++; if (vs_done !== 1'b1 || dm_addr !== 32'h600) begin
            bad++; $display("FAIL b2b_first got done=%b addr=%h want 1/00000600", vs_done, dm_addr);
        end
        start_vec(32'h700, 32'd4, 5'd1, 2'd2);
        #1;
        total++; if (vs_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", vs_ready); end
        tick();
        vs_valid = 1'b0; vs_elem_data = 32'h77;
        total++; if (vs_done !== 1'b0 || dm_write !== 4'b0000) begin
            bad++; $display("FAIL b2b_gap got done=%b we=%b want 0/0000", vs_done, dm_write);
        end
        tick();
        total++; if (vs_done !== 1'b1 || dm_addr !== 32'h700 || dm_wdata !== 32'h77) begin
            bad++; $display("FAIL b2b_second got done=%b addr=%h data=%h want 1/00000700/00000077", vs_done, dm_addr, dm_wdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_vec;
        int seen_done = 0;
        int seen_write = 0;
        start_vec(32'h800, 32'd4, 5'd4, 2'd2);
        tick();
        vs_valid = 1'b0; vs_elem_data = 32'h88;
        tick();
        total++; if (dm_addr !== 32'h800 || dm_write !== 4'b1111) begin
            bad++; $display("FAIL rmid_first got addr=%h we=%b want 00000800/1111", dm_addr, dm_write);
        end
        rst = 1'b1;
        #1;
        total++; if (vs_elem_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got %b want 0", vs_elem_ack); end
        tick();
        rst = 1'b0;
        total++; if ({dm_addr, dm_wdata, dm_write, st_misalign, vs_done} !== 70'd0) begin
            bad++; $display("FAIL rmid_clear got addr=%h wdata=%h we=%b mis=%b done=%b want all zero",
                            dm_addr, dm_wdata, dm_write, st_misalign, vs_done);
        end
        for (int c = 0; c < 5; c++) begin
            if (vs_elem_ack !== 1'b0) seen_write++;
            tick();
            if (vs_done !== 1'b0) seen_done++;
            if (dm_write !== 4'b0000) seen_write++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL rmid_no_done got %0d pulses want 0", seen_done); end
        total++; if (seen_write !== 0) begin bad++; $display("FAIL rmid_no_write got %0d writes want 0", seen_write); end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_contention();
        test_count_zero();
        test_back_to_back();
        test_reset_mid_vec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
